// File: rtl/soc_top_pkg.sv
`default_nettype none
// ============================================================================
// soc_top_pkg : shared state/memory-select types, defaults, pad tie-offs
// Rev 1.0
// ============================================================================
package soc_top_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      MEM_WEIGHT = 2'd0,
      MEM_IMAGE  = 2'd1,
      MEM_OUT    = 2'd2
   } mem_sel_e;

   localparam int c_N_WORDS_DEF   = 16;
   localparam int c_OUT_DEPTH_DEF = 4096;
   localparam int c_IDX_W         = 16;

   localparam logic [31:0] c_GPIOA_OE = 32'h8000_FFFF;
   localparam logic [31:0] c_GPIOB_OE = 32'hFFFF_FFFF;

   localparam logic c_HFXOSCEN     = 1'b1;
   localparam logic c_LFXOSCEN     = 1'b1;
   localparam logic c_TDO_OVAL     = 1'b0;
   localparam logic c_TDO_OE       = 1'b0;
   localparam logic c_QSPI_SCK     = 1'b0;
   localparam logic c_QSPI_CS0     = 1'b1;
   localparam logic c_QSPI_DQ_OVAL = 1'b0;
   localparam logic c_QSPI_DQ_OE   = 1'b0;

   // Two 16x16 unsigned products summed; the carry out of bit 31 is dropped.
   function automatic logic [31:0] mac2(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] lo;
      logic [31:0] hi;
      lo = {16'd0, a[15:0]}  * {16'd0, b[15:0]};
      hi = {16'd0, a[31:16]} * {16'd0, b[31:16]};
      return lo + hi;
   endfunction

endpackage
`default_nettype wire

// File: rtl/soc_top_if.sv
`default_nettype none
// ============================================================================
// soc_top_if : engine <-> word-memory bus (async read, clocked write)
// Rev 1.0
// ============================================================================
interface soc_top_if
   import soc_top_pkg::*;
#(
   parameter int AW = 4
) ();

   logic [AW-1:0] rd_addr;
   logic [31:0]   rd_wgt;
   logic [31:0]   rd_img;
   logic          wr_en;
   mem_sel_e      wr_sel;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_data;

   modport master (
      output rd_addr,
      input  rd_wgt,
      input  rd_img,
      output wr_en,
      output wr_sel,
      output wr_addr,
      output wr_data
   );

   modport slave (
      input  rd_addr,
      output rd_wgt,
      output rd_img,
      input  wr_en,
      input  wr_sel,
      input  wr_addr,
      input  wr_data
   );

endinterface
`default_nettype wire

// File: rtl/soc_top_mac_engine.sv
`default_nettype none
// ============================================================================
// soc_mac_engine : IDLE/RUN/DONE sequencer, index counter, multiply-add and
//                  (with SOC_GPIOB_EN) running checksum
// Rev 1.0
// ============================================================================
module soc_mac_engine
   import soc_top_pkg::*;
#(
   parameter int N_WORDS = c_N_WORDS_DEF
) (
   input  logic               hfclk,
   input  logic               rst_n,
   input  logic               i_bootrom_n,
   input  logic               i_dwakeup_n,
   input  logic               i_halt,
   soc_top_if.master          bus,
   output logic               o_done,
   output logic [c_IDX_W-1:0] o_index
`ifdef SOC_GPIOB_EN
   ,
   output logic [31:0]        o_csum
`endif
);

   localparam int                 AW     = $clog2(N_WORDS);
   localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(N_WORDS - 1);

   state_e               r_state;
   state_e               w_state_nxt;
   logic [c_IDX_W-1:0]   r_idx;
   logic [c_IDX_W-1:0]   w_idx_nxt;
   logic                 r_first;
   logic                 w_first_nxt;
   logic                 w_wr_en;
   logic [31:0]          w_mac;
`ifdef SOC_GPIOB_EN
   logic [31:0]          r_csum;
   logic [31:0]          w_csum_nxt;
`endif

   assign w_mac = mac2(bus.rd_wgt, bus.rd_img);

   always_ff @(posedge hfclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_first <= 1'b1;
`ifdef SOC_GPIOB_EN
         r_csum  <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_first <= w_first_nxt;
`ifdef SOC_GPIOB_EN
         r_csum  <= w_csum_nxt;
`endif
      end
   end

   // A halt leaves every register and the write strobe untouched.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_first_nxt = r_first;
      w_wr_en     = 1'b0;
`ifdef SOC_GPIOB_EN
      w_csum_nxt  = r_csum;
`endif
      if (!i_halt) begin
         w_first_nxt = 1'b0;
         case (r_state)
            IDLE: begin
               // Autorun is only honoured on the first cycle out of reset.
               if (r_first && !i_bootrom_n) begin
                  w_state_nxt = RUN;
                  w_idx_nxt   = '0;
               end
            end
            RUN: begin
               w_wr_en = 1'b1;
`ifdef SOC_GPIOB_EN
               w_csum_nxt = r_csum + w_mac;
`endif
               if (r_idx == c_LAST) begin
                  w_state_nxt = DONE;
               end else begin
                  w_idx_nxt = r_idx + c_IDX_W'(1);
               end
            end
            DONE: begin
               if (!i_dwakeup_n) begin
                  w_state_nxt = RUN;
                  w_idx_nxt   = '0;
`ifdef SOC_GPIOB_EN
                  w_csum_nxt  = '0;
`endif
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   assign bus.rd_addr = r_idx[AW-1:0];
   assign bus.wr_en   = w_wr_en;
   assign bus.wr_sel  = MEM_OUT;
   assign bus.wr_addr = r_idx[AW-1:0];
   assign bus.wr_data = w_mac;

   assign o_done  = (r_state == DONE);
   assign o_index = r_idx;
`ifdef SOC_GPIOB_EN
   assign o_csum  = r_csum;
`endif

endmodule
`default_nettype wire

// File: rtl/soc_top.sv
`default_nettype none
// ============================================================================
// soc_top : word memories, MAC engine and pad tie-offs.
//           Optional macro SOC_GPIOB_EN exposes the checksum on gpioB.
// Rev 1.0
// ============================================================================
module soc_top
   import soc_top_pkg::*;
#(
   parameter int N_WORDS   = c_N_WORDS_DEF,
   parameter int OUT_DEPTH = c_OUT_DEPTH_DEF
) (
   input  logic        hfclk,
   input  logic        rst_n,
   input  logic        lfextclk,
   output logic        hfxoscen,
   output logic        lfxoscen,
   input  logic        io_pads_jtag_TCK_i_ival,
   input  logic        io_pads_jtag_TMS_i_ival,
   input  logic        io_pads_jtag_TDI_i_ival,
   output logic        io_pads_jtag_TDO_o_oval,
   output logic        io_pads_jtag_TDO_o_oe,
   input  logic [31:0] io_pads_gpioA_i_ival,
   output logic [31:0] io_pads_gpioA_o_oval,
   output logic [31:0] io_pads_gpioA_o_oe,
   input  logic [31:0] io_pads_gpioB_i_ival,
   output logic [31:0] io_pads_gpioB_o_oval,
   output logic [31:0] io_pads_gpioB_o_oe,
   output logic        io_pads_qspi0_sck_o_oval,
   output logic        io_pads_qspi0_cs_0_o_oval,
   input  logic        io_pads_qspi0_dq_0_i_ival,
   output logic        io_pads_qspi0_dq_0_o_oval,
   output logic        io_pads_qspi0_dq_0_o_oe,
   input  logic        io_pads_qspi0_dq_1_i_ival,
   output logic        io_pads_qspi0_dq_1_o_oval,
   output logic        io_pads_qspi0_dq_1_o_oe,
   input  logic        io_pads_qspi0_dq_2_i_ival,
   output logic        io_pads_qspi0_dq_2_o_oval,
   output logic        io_pads_qspi0_dq_2_o_oe,
   input  logic        io_pads_qspi0_dq_3_i_ival,
   output logic        io_pads_qspi0_dq_3_o_oval,
   output logic        io_pads_qspi0_dq_3_o_oe,
   input  logic        io_pads_aon_pmu_dwakeup_n_i_ival,
   output logic        io_pads_aon_pmu_vddpaden_o_oval,
   output logic        io_pads_aon_pmu_padrst_o_oval,
   input  logic        io_pads_bootrom_n_i_ival,
   input  logic        io_pads_dbgmode0_n_i_ival,
   input  logic        io_pads_dbgmode1_n_i_ival,
   input  logic        io_pads_dbgmode2_n_i_ival
);

   localparam int AW  = $clog2(N_WORDS);
   localparam int OAW = $clog2(OUT_DEPTH);

   logic               w_halt;
   logic               w_done;
   logic [c_IDX_W-1:0] w_index;
   logic               w_unused;

   soc_top_if #(.AW(AW)) u_bus ();

   assign w_halt = ~(io_pads_dbgmode0_n_i_ival & io_pads_dbgmode1_n_i_ival &
                     io_pads_dbgmode2_n_i_ival);

`ifdef SOC_GPIOB_EN
   logic [31:0] w_csum;
`endif

   soc_mac_engine #(.N_WORDS(N_WORDS)) u_engine (
      .hfclk       (hfclk),
      .rst_n       (rst_n),
      .i_bootrom_n (io_pads_bootrom_n_i_ival),
      .i_dwakeup_n (io_pads_aon_pmu_dwakeup_n_i_ival),
      .i_halt      (w_halt),
      .bus         (u_bus.master),
      .o_done      (w_done),
      .o_index     (w_index)
`ifdef SOC_GPIOB_EN
      ,
      .o_csum      (w_csum)
`endif
   );

   // Memories are never reset so preloaded and computed data survive rst_n.
   if (1) begin : g_weight
      logic [31:0] mem_r [N_WORDS];
      always_ff @(posedge hfclk) begin
         if (u_bus.wr_en && (u_bus.wr_sel == MEM_WEIGHT)) begin
            mem_r[u_bus.wr_addr] <= u_bus.wr_data;
         end
      end
      assign u_bus.rd_wgt = mem_r[u_bus.rd_addr];
   end

   if (1) begin : g_image
      logic [31:0] mem_r [N_WORDS];
      always_ff @(posedge hfclk) begin
         if (u_bus.wr_en && (u_bus.wr_sel == MEM_IMAGE)) begin
            mem_r[u_bus.wr_addr] <= u_bus.wr_data;
         end
      end
      assign u_bus.rd_img = mem_r[u_bus.rd_addr];
   end

   if (1) begin : g_out
      logic [31:0]    mem_r [OUT_DEPTH];
      logic [OAW-1:0] w_addr;
      logic           w_unused_rd;
      assign w_addr      = OAW'(u_bus.wr_addr);
      assign w_unused_rd = ^mem_r[0];
      always_ff @(posedge hfclk) begin
         if (u_bus.wr_en && (u_bus.wr_sel == MEM_OUT)) begin
            mem_r[w_addr] <= u_bus.wr_data;
         end
      end
   end

   assign io_pads_gpioA_o_oval = {w_done, 15'd0, w_index};
   assign io_pads_gpioA_o_oe   = c_GPIOA_OE;

`ifdef SOC_GPIOB_EN
   // The running sum is hidden until the run has finished.
   assign io_pads_gpioB_o_oval = w_done ? w_csum : 32'd0;
   assign io_pads_gpioB_o_oe   = c_GPIOB_OE;
`else
   assign io_pads_gpioB_o_oval = 32'd0;
   assign io_pads_gpioB_o_oe   = 32'd0;
`endif

   assign hfxoscen                  = c_HFXOSCEN;
   assign lfxoscen                  = c_LFXOSCEN;
   assign io_pads_jtag_TDO_o_oval   = c_TDO_OVAL;
   assign io_pads_jtag_TDO_o_oe     = c_TDO_OE;
   assign io_pads_qspi0_sck_o_oval  = c_QSPI_SCK;
   assign io_pads_qspi0_cs_0_o_oval = c_QSPI_CS0;
   assign io_pads_qspi0_dq_0_o_oval = c_QSPI_DQ_OVAL;
   assign io_pads_qspi0_dq_0_o_oe   = c_QSPI_DQ_OE;
   assign io_pads_qspi0_dq_1_o_oval = c_QSPI_DQ_OVAL;
   assign io_pads_qspi0_dq_1_o_oe   = c_QSPI_DQ_OE;
   assign io_pads_qspi0_dq_2_o_oval = c_QSPI_DQ_OVAL;
   assign io_pads_qspi0_dq_2_o_oe   = c_QSPI_DQ_OE;
   assign io_pads_qspi0_dq_3_o_oval = c_QSPI_DQ_OVAL;
   assign io_pads_qspi0_dq_3_o_oe   = c_QSPI_DQ_OE;

   assign io_pads_aon_pmu_vddpaden_o_oval = rst_n;
   assign io_pads_aon_pmu_padrst_o_oval   = ~rst_n;

   assign w_unused = ^{lfextclk, io_pads_jtag_TCK_i_ival, io_pads_jtag_TMS_i_ival,
                       io_pads_jtag_TDI_i_ival, io_pads_gpioA_i_ival, io_pads_gpioB_i_ival,
                       io_pads_qspi0_dq_0_i_ival, io_pads_qspi0_dq_1_i_ival,
                       io_pads_qspi0_dq_2_i_ival, io_pads_qspi0_dq_3_i_ival};

endmodule
`default_nettype wire

// File: tb/tb_soc_top.sv
`default_nettype none
// ============================================================================
// tb_soc_top : vector table + randomized data against a word-level model
// Rev 1.0
// ============================================================================
module tb_soc_top;
   import soc_top_pkg::*;

   localparam int NW = 16;
   localparam int OD = 4096;

   logic        hfclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        lfextclk = 1'b0;
   logic        hfxoscen, lfxoscen;
   logic        tck = 1'b0, tms = 1'b0, tdi = 1'b0, tdo, tdo_oe;
   logic [31:0] ga_i = 32'h0, ga_o, ga_oe, gb_i = 32'h0, gb_o, gb_oe;
   logic        sck, cs0;
   logic [3:0]  dq_i = 4'h0, dq_o, dq_oe;
   logic        dwakeup_n = 1'b1, vddpaden, padrst;
   logic        bootrom_n = 1'b0;
   logic        dbg0_n = 1'b1, dbg1_n = 1'b1, dbg2_n = 1'b1;

   always #5 hfclk = ~hfclk;

   soc_top #(.N_WORDS(NW), .OUT_DEPTH(OD)) dut (
      .hfclk(hfclk), .rst_n(rst_n), .lfextclk(lfextclk),
      .hfxoscen(hfxoscen), .lfxoscen(lfxoscen),
      .io_pads_jtag_TCK_i_ival(tck), .io_pads_jtag_TMS_i_ival(tms),
      .io_pads_jtag_TDI_i_ival(tdi), .io_pads_jtag_TDO_o_oval(tdo),
      .io_pads_jtag_TDO_o_oe(tdo_oe),
      .io_pads_gpioA_i_ival(ga_i), .io_pads_gpioA_o_oval(ga_o), .io_pads_gpioA_o_oe(ga_oe),
      .io_pads_gpioB_i_ival(gb_i), .io_pads_gpioB_o_oval(gb_o), .io_pads_gpioB_o_oe(gb_oe),
      .io_pads_qspi0_sck_o_oval(sck), .io_pads_qspi0_cs_0_o_oval(cs0),
      .io_pads_qspi0_dq_0_i_ival(dq_i[0]), .io_pads_qspi0_dq_0_o_oval(dq_o[0]),
      .io_pads_qspi0_dq_0_o_oe(dq_oe[0]),
      .io_pads_qspi0_dq_1_i_ival(dq_i[1]), .io_pads_qspi0_dq_1_o_oval(dq_o[1]),
      .io_pads_qspi0_dq_1_o_oe(dq_oe[1]),
      .io_pads_qspi0_dq_2_i_ival(dq_i[2]), .io_pads_qspi0_dq_2_o_oval(dq_o[2]),
      .io_pads_qspi0_dq_2_o_oe(dq_oe[2]),
      .io_pads_qspi0_dq_3_i_ival(dq_i[3]), .io_pads_qspi0_dq_3_o_oval(dq_o[3]),
      .io_pads_qspi0_dq_3_o_oe(dq_oe[3]),
      .io_pads_aon_pmu_dwakeup_n_i_ival(dwakeup_n),
      .io_pads_aon_pmu_vddpaden_o_oval(vddpaden),
      .io_pads_aon_pmu_padrst_o_oval(padrst),
      .io_pads_bootrom_n_i_ival(bootrom_n),
      .io_pads_dbgmode0_n_i_ival(dbg0_n),
      .io_pads_dbgmode1_n_i_ival(dbg1_n),
      .io_pads_dbgmode2_n_i_ival(dbg2_n)
   );

   soc_top_if #(.AW(4)) u_mon ();
   assign u_mon.rd_addr = dut.u_bus.rd_addr;
   assign u_mon.rd_wgt  = dut.u_bus.rd_wgt;
   assign u_mon.rd_img  = dut.u_bus.rd_img;
   assign u_mon.wr_en   = dut.u_bus.wr_en;
   assign u_mon.wr_sel  = dut.u_bus.wr_sel;
   assign u_mon.wr_addr = dut.u_bus.wr_addr;
   assign u_mon.wr_data = dut.u_bus.wr_data;

   typedef struct {
      logic [31:0] w;
      logic [31:0] img;
      logic [31:0] exp_out;
   } vec_t;

   vec_t        vecs[5];
   logic [31:0] wv[NW];
   logic [31:0] iv[NW];
   int          n_chk = 0;
   int          n_fail = 0;
   int          n_wr = 0;
   int          cyc;
   logic [31:0] exp_b, exp_boe;

   function automatic logic [31:0] ref_mac(input logic [31:0] w, input logic [31:0] img);
      logic [63:0] wl, wh, il, ih, s;
      wl = 64'(w) % 64'd65536;   wh = 64'(w) / 64'd65536;
      il = 64'(img) % 64'd65536; ih = 64'(img) / 64'd65536;
      s  = wl * il + wh * ih;
      return s[31:0];
   endfunction

   function automatic logic [31:0] ref_csum();
      logic [31:0] s = 32'd0;
      for (int i = 0; i < NW; i++) s = s + ref_mac(wv[i], iv[i]);
      return s;
   endfunction

   function automatic int count_bad_out();
      int n = 0;
      for (int i = 0; i < NW; i++)
         if (dut.g_out.mem_r[i] !== ref_mac(wv[i], iv[i])) n++;
      return n;
   endfunction

   function automatic int count_nonzero(input int from);
      int n = 0;
      for (int i = from; i < OD; i++)
         if (dut.g_out.mem_r[i] !== 32'd0) n++;
      return n;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic preload();
      for (int i = 0; i < NW; i++) begin
         dut.g_weight.mem_r[i] = wv[i];
         dut.g_image.mem_r[i]  = iv[i];
      end
      for (int j = 0; j < OD; j++) dut.g_out.mem_r[j] = 32'd0;
   endtask

   task automatic pulse_reset();
      @(negedge hfclk) rst_n = 1'b0;
      repeat (2) @(negedge hfclk);
      rst_n = 1'b1;
   endtask

   // Called at a negedge; counts rising edges until done is seen.
   task automatic wait_done(input int budget, input int halt_at, input int halt_len,
                            output int cycles);
      cycles = 0;
      while (!ga_o[31] && cycles < budget) begin
         @(posedge hfclk);
         cycles++;
         @(negedge hfclk);
         if (halt_at > 0 && cycles == halt_at) dbg0_n = 1'b0;
         if (halt_at > 0 && cycles == halt_at + halt_len) begin
            check("halt_index_frozen", ga_o, 32'(halt_at - 1));
            dbg0_n = 1'b1;
         end
      end
      if (!ga_o[31]) check("done_timeout", 32'(cycles), 32'(budget + 1));
   endtask

   // Every write must carry the model value of the memories it read.
   always @(negedge hfclk) begin
      #2;
      if (u_mon.wr_en) begin
         n_wr++;
         check("wr_rd_wgt", u_mon.rd_wgt, wv[u_mon.rd_addr]);
         check("wr_rd_img", u_mon.rd_img, iv[u_mon.rd_addr]);
         check("wr_data", u_mon.wr_data, ref_mac(wv[u_mon.wr_addr], iv[u_mon.wr_addr]));
         check("wr_sel", 32'(u_mon.wr_sel), 32'(MEM_OUT));
      end
   end

   initial begin
      vecs[0] = '{w: 32'h005A_00CD, img: 32'h00A1_0031, exp_out: 32'h0000_5FD7};
      vecs[1] = '{w: 32'h00D9_00B7, img: 32'h00B6_0009, exp_out: 32'h0000_A0B5};
      vecs[2] = '{w: 32'hFFFF_FFFF, img: 32'hFFFF_FFFF, exp_out: 32'hFFFC_0002};
      vecs[3] = '{w: 32'h0001_0000, img: 32'h0001_0000, exp_out: 32'h0000_0001};
      vecs[4] = '{w: 32'h1234_5678, img: 32'h0000_0000, exp_out: 32'h0000_0000};
      for (int i = 0; i < NW; i++) begin
         wv[i] = (i < 5) ? vecs[i].w   : $urandom;
         iv[i] = (i < 5) ? vecs[i].img : $urandom;
      end
      ga_i = $urandom; gb_i = $urandom; dq_i = 4'($urandom);
      preload();

      // Reset values, then autorun
      repeat (2) @(negedge hfclk);
      check("rst_gpioA", ga_o, 32'd0);
      check("rst_pads", {30'd0, padrst, vddpaden}, 32'h2);
      check("rst_gpioB", gb_o, 32'd0);
      rst_n = 1'b1;
      n_wr  = 0;
      wait_done(100, 0, 0, cyc);
      check("done_latency", 32'(cyc), 32'(NW + 1));
      for (int i = 0; i < 5; i++) check($sformatf("vec_out[%0d]", i), dut.g_out.mem_r[i], vecs[i].exp_out);
      check("rand_out_bad", 32'(count_bad_out()), 32'd0);
      check("upper_out_zero", 32'(count_nonzero(NW)), 32'd0);
      check("done_gpioA", ga_o, 32'h8000_0000 | 32'(NW - 1));
      check("gpioA_oe", ga_oe, 32'h8000_FFFF);
      check("tieoffs", {18'd0, hfxoscen, lfxoscen, tdo, tdo_oe, sck, cs0, dq_o, dq_oe}, 32'h3100);
      check("run_pads", {30'd0, padrst, vddpaden}, 32'h1);
`ifdef SOC_GPIOB_EN
      exp_b = ref_csum(); exp_boe = 32'hFFFF_FFFF;
`else
      exp_b = 32'd0;      exp_boe = 32'd0;
`endif
      check("gpioB_csum", gb_o, exp_b);
      check("gpioB_oe", gb_oe, exp_boe);
      check("write_count", 32'(n_wr), 32'(NW));

      // Five-cycle debug halt mid-run
      preload();
      pulse_reset();
      n_wr = 0;
      wait_done(100, 6, 5, cyc);
      check("halt_latency", 32'(cyc), 32'(NW + 1 + 5));
      check("halt_out_bad", 32'(count_bad_out()), 32'd0);
      check("halt_write_count", 32'(n_wr), 32'(NW));

      // Reset at i=8: memory kept, run restarts from 0
      for (int i = 0; i < NW; i++) begin
         wv[i] = $urandom;
         iv[i] = $urandom;
      end
      preload();
      pulse_reset();
      n_wr = 0;
      repeat (9) @(posedge hfclk);
      @(negedge hfclk);
      check("pre_reset_index", ga_o, 32'd8);
      rst_n = 1'b0;
      #1;
      check("midrun_rst_gpioA", ga_o, 32'd0);
      check("midrun_rst_padrst", {31'd0, padrst}, 32'd1);
      check("out_kept_in_reset", dut.g_out.mem_r[3], ref_mac(wv[3], iv[3]));
      check("out8_unwritten", dut.g_out.mem_r[8], 32'd0);
      @(negedge hfclk) rst_n = 1'b1;
      wait_done(100, 0, 0, cyc);
      check("restart_latency", 32'(cyc), 32'(NW + 1));
      check("restart_out_bad", 32'(count_bad_out()), 32'd0);
      check("restart_upper_zero", 32'(count_nonzero(NW)), 32'd0);
      check("restart_write_count", 32'(n_wr), 32'(8 + NW));

      // DONE holds until dwakeup_n, then an identical rerun
      repeat (5) @(negedge hfclk);
      check("done_held", ga_o, 32'h8000_0000 | 32'(NW - 1));
      n_wr = 0;
      dwakeup_n = 1'b0;
      @(posedge hfclk);
      @(negedge hfclk) dwakeup_n = 1'b1;
      check("wake_gpioA", ga_o, 32'd0);
      check("wake_gpioB_hidden", gb_o, 32'd0);
      wait_done(100, 0, 0, cyc);
      check("wake_latency", 32'(cyc), 32'(NW));
`ifdef SOC_GPIOB_EN
      exp_b = ref_csum();
`else
      exp_b = 32'd0;
`endif
      check("wake_gpioB_csum", gb_o, exp_b);
      check("wake_out_bad", 32'(count_bad_out()), 32'd0);
      check("wake_write_count", 32'(n_wr), 32'(NW));

      // bootrom_n=1: stays IDLE even if the pin drops later
      bootrom_n = 1'b1;
      preload();
      pulse_reset();
      n_wr = 0;
      repeat (2) @(negedge hfclk);
      bootrom_n = 1'b0;
      repeat (30) @(negedge hfclk);
      check("idle_gpioA", ga_o, 32'd0);
      check("idle_out_zero", 32'(count_nonzero(0)), 32'd0);
      check("idle_write_count", 32'(n_wr), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
